// File: rtl/nibble_sequencer_pkg.sv
// Shared types and constants for the Zigbee TX nibble sequencer.
// Holds the FSM state encoding and the nibble-ordering helper.
package nibble_sequencer_pkg;

  localparam int LANE_COUNT        = 4;
  localparam int SEL_W             = 2;
  localparam bit LSB_FIRST_DEFAULT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_SECOND
  } state_e;

  function automatic logic [3:0] pick_nibble(input logic [7:0] b, input logic take_low);
    return take_low ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/nibble_sequencer_if.sv
// Byte-in / nibble-out bundle between the byte feeder, the sequencer and the demux.
// The master drives bytes and flow control; the slave (the sequencer) drives symbols.
interface nibble_sequencer_if;
  import nibble_sequencer_pkg::*;

  logic [7:0]       inByte;
  logic             inByteValid;
  logic             outByteReady;
  logic             inHold;
  logic             inFlush;
  logic [3:0]       outNibble;
  logic [SEL_W-1:0] outSel;
  logic             outNibbleValid;
  logic             outWordDone;
  logic             outBusy;

  modport master (
    output inByte, inByteValid, inHold, inFlush,
    input  outByteReady, outNibble, outSel, outNibbleValid, outWordDone, outBusy
  );

  modport slave (
    input  inByte, inByteValid, inHold, inFlush,
    output outByteReady, outNibble, outSel, outNibbleValid, outWordDone, outBusy
  );

endinterface

// File: rtl/nibble_sequencer.sv
// Splits accepted bytes into two nibbles and walks a persistent 4-lane select,
// flagging the lane-3 nibble as the end of a 16-bit demux word.
module nibble_sequencer
  import nibble_sequencer_pkg::*;
#(
  parameter bit LSB_FIRST = LSB_FIRST_DEFAULT,
  parameter int LANES     = LANE_COUNT
) (
  input  logic              inClock,
  input  logic              inResetN,
  nibble_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] lane_q,  lane_d;
  logic [7:0]       buf_q,   buf_d;

  logic ready;
  logic accept;
  logic nibble_valid;

  assign nibble_valid = (state_q != ST_IDLE);

  // Ready is held low during reset so nothing can slip in while the block is cleared.
  assign ready  = inResetN & ~bus.inHold & ~bus.inFlush &
                  ((state_q == ST_IDLE) | (state_q == ST_SECOND));
  assign accept = bus.inByteValid & ready;

  // NOTE: every variable driven here gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    buf_d   = buf_q;

    if (accept) buf_d = bus.inByte;

    case (state_q)
      ST_IDLE:   if (accept)       state_d = ST_FIRST;
      ST_FIRST:  if (!bus.inHold)  state_d = ST_SECOND;
      ST_SECOND: if (!bus.inHold)  state_d = accept ? ST_FIRST : ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase

    // The lane survives idle gaps so one demux word may span separated bytes.
    if (nibble_valid && !bus.inHold) lane_d = lane_q + SEL_W'(1);

    if (bus.inFlush) begin
      state_d = ST_IDLE;
      lane_d  = '0;
    end
  end

  // NOTE: state uses non-blocking assignments and an asynchronous clear, so outputs drop the moment reset asserts.
  always_ff @(posedge inClock or negedge inResetN) begin
    if (!inResetN) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      buf_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.outByteReady   = ready;
  assign bus.outNibbleValid = nibble_valid;
  assign bus.outSel         = lane_q;
  assign bus.outNibble      = nibble_valid ?
                              pick_nibble(buf_q, (state_q == ST_FIRST) == LSB_FIRST) : 4'h0;
  assign bus.outWordDone    = nibble_valid & (lane_q == SEL_W'(LANES - 1));
  assign bus.outBusy        = nibble_valid | (lane_q != '0);

endmodule

// File: tb/tb_nibble_sequencer.sv
// Scoreboard bench for nibble_sequencer: one LSB-first and one MSB-first instance,
// directed bytes with hand-computed nibble/lane/word-done expectations.
module tb_nibble_sequencer;
  import nibble_sequencer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_sequencer_if bus_a ();
  nibble_sequencer_if bus_b ();

  nibble_sequencer #(.LSB_FIRST(1'b1), .LANES(4)) u_lsb (
    .inClock  (clk),
    .inResetN (rst_n),
    .bus      (bus_a)
  );

  nibble_sequencer #(.LSB_FIRST(1'b0), .LANES(4)) u_msb (
    .inClock  (clk),
    .inResetN (rst_n),
    .bus      (bus_b)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic [1:0] sel;
    logic       done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // A nibble is consumed when it is valid and not stalled by hold.
  always @(negedge clk) begin
    if (rst_n && bus_a.outNibbleValid && !bus_a.inHold) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected actual nib=%h sel=%0d required=none",
                 bus_a.outNibble, bus_a.outSel);
      end else begin
        e_a = q_a.pop_front();
        check("a_nibble", {bus_a.outNibble, bus_a.outSel, bus_a.outWordDone}, e_a);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_b.outNibbleValid && !bus_b.inHold) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected actual nib=%h sel=%0d required=none",
                 bus_b.outNibble, bus_b.outSel);
      end else begin
        e_b = q_b.pop_front();
        check("b_nibble", {bus_b.outNibble, bus_b.outSel, bus_b.outWordDone}, e_b);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit to_b, input logic [7:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    if (to_b) begin bus_b.inByte = b; bus_b.inByteValid = 1'b1; end
    else      begin bus_a.inByte = b; bus_a.inByteValid = 1'b1; end
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = to_b ? bus_b.outByteReady : bus_a.outByteReady;
      @(posedge clk);
      #1;
      n++;
    end
    check(to_b ? "b_accept" : "a_accept", 32'(acc), 32'd1);
    if (to_b) bus_b.inByteValid = 1'b0;
    else      bus_a.inByteValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.inByte = 8'h00; bus_a.inByteValid = 1'b0; bus_a.inHold = 1'b0; bus_a.inFlush = 1'b0;
    bus_b.inByte = 8'h00; bus_b.inByteValid = 1'b0; bus_b.inHold = 1'b0; bus_b.inFlush = 1'b0;

    // Reset state, including ready forced low while reset is asserted.
    #2;
    check("a_reset_outputs", {bus_a.outNibble, bus_a.outSel, bus_a.outNibbleValid,
                              bus_a.outWordDone, bus_a.outBusy, bus_a.outByteReady}, 32'd0);
    check("b_reset_outputs", {bus_b.outNibble, bus_b.outSel, bus_b.outNibbleValid,
                              bus_b.outWordDone, bus_b.outBusy, bus_b.outByteReady}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("a_idle_after_reset", {bus_a.outNibbleValid, bus_a.outBusy, bus_a.outByteReady}, 32'b001);

    // Back-to-back bytes 0xA7, 0x3C, low nibble first.
    q_a.push_back(exp_t'{4'h7, 2'd0, 1'b0});
    q_a.push_back(exp_t'{4'hA, 2'd1, 1'b0});
    q_a.push_back(exp_t'{4'hC, 2'd2, 1'b0});
    q_a.push_back(exp_t'{4'h3, 2'd3, 1'b1});
    send(1'b0, 8'hA7);
    bus_a.inByte = 8'h3C; bus_a.inByteValid = 1'b1;
    @(negedge clk);
    check("a_ready_in_first", 32'(bus_a.outByteReady), 32'd0);
    @(posedge clk); #1;
    send(1'b0, 8'h3C);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("a_idle_word_complete", {bus_a.outNibbleValid, bus_a.outBusy}, 32'b00);
    @(posedge clk); #1;

    // High nibble first; the lane stays at 2 across the idle state.
    q_b.push_back(exp_t'{4'hA, 2'd0, 1'b0});
    q_b.push_back(exp_t'{4'h7, 2'd1, 1'b0});
    send(1'b1, 8'hA7);
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_idle_valid", 32'(bus_b.outNibbleValid), 32'd0);
    check("b_idle_busy",  32'(bus_b.outBusy), 32'd1);
    check("b_idle_sel",   32'(bus_b.outSel), 32'd2);
    @(posedge clk); #1;

    // Hold for three cycles while nibble C sits on lane 2.
    q_a.push_back(exp_t'{4'h7, 2'd0, 1'b0});
    q_a.push_back(exp_t'{4'hA, 2'd1, 1'b0});
    q_a.push_back(exp_t'{4'hC, 2'd2, 1'b0});
    q_a.push_back(exp_t'{4'h3, 2'd3, 1'b1});
    send(1'b0, 8'hA7);
    bus_a.inByte = 8'h3C; bus_a.inByteValid = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 8'h3C);
    bus_a.inHold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("a_hold_frozen", {bus_a.outNibble, bus_a.outSel, bus_a.outNibbleValid,
                              bus_a.outWordDone, bus_a.outByteReady}, {4'hC, 2'd2, 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    bus_a.inHold = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Flush after the first nibble of 0xA7; a byte offered alongside is refused.
    q_a.push_back(exp_t'{4'h7, 2'd0, 1'b0});
    q_a.push_back(exp_t'{4'h5, 2'd0, 1'b0});
    q_a.push_back(exp_t'{4'h5, 2'd1, 1'b0});
    send(1'b0, 8'hA7);
    bus_a.inFlush = 1'b1;
    bus_a.inByte = 8'hEE; bus_a.inByteValid = 1'b1;
    @(negedge clk);
    check("a_ready_in_flush", 32'(bus_a.outByteReady), 32'd0);
    @(posedge clk); #1;
    bus_a.inFlush = 1'b0; bus_a.inByteValid = 1'b0;
    @(negedge clk);
    check("a_after_flush", {bus_a.outNibbleValid, bus_a.outSel, bus_a.outBusy}, 32'd0);
    @(posedge clk); #1;
    send(1'b0, 8'h55);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset between edges while the second nibble is showing.
    q_a.push_back(exp_t'{4'hB, 2'd2, 1'b0});
    send(1'b0, 8'h9B);
    @(posedge clk); #1;
    check("a_second_before_reset", {bus_a.outNibble, bus_a.outSel, bus_a.outWordDone},
          {4'h9, 2'd3, 1'b1});
    #1 rst_n = 1'b0;
    #1;
    check("a_async_reset_outputs", {bus_a.outNibble, bus_a.outSel, bus_a.outNibbleValid,
                                    bus_a.outWordDone, bus_a.outBusy, bus_a.outByteReady}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Word spanning an idle gap: 0x12, idle, 0x34, starting from lane 0 after reset.
    q_a.push_back(exp_t'{4'h2, 2'd0, 1'b0});
    q_a.push_back(exp_t'{4'h1, 2'd1, 1'b0});
    q_a.push_back(exp_t'{4'h4, 2'd2, 1'b0});
    q_a.push_back(exp_t'{4'h3, 2'd3, 1'b1});
    send(1'b0, 8'h12);
    repeat (6) @(posedge clk);
    #1;
    send(1'b0, 8'h34);
    repeat (4) @(posedge clk);
    #1;

    check("a_scoreboard_drained", 32'(q_a.size()), 32'd0);
    check("b_scoreboard_drained", 32'(q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
